// File: rtl/alu_div_sequencer.sv
// Iterative 32-bit unsigned restoring divider that borrows the core ALU for
// every compare and subtract; one quotient bit per CMP/SUB cycle pair.
`timescale 1ns/1ps
module alu_div_sequencer #(
  parameter int         W      = 32,
  parameter logic [3:0] OP_OR  = 4'd1,
  parameter logic [3:0] OP_SUB = 4'd6,
  parameter logic [3:0] OP_SLT = 4'd7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_r,
  input  logic         alu_zero
);

  typedef enum logic [2:0] {IDLE, CHK, CMP, SUB, FIN} state_t;

  state_t       state;
  logic [W-1:0] dvs, q, rem;
  logic [4:0]   cnt;
  logic         ge, dbz;
  logic [W-1:0] s, q_nxt, rem_nxt;

  // Shifted partial remainder; its dropped MSB (rem[W-1]) is the carry that forces a subtract.
  assign s = {rem[W-2:0], q[W-1]};

  always_comb begin
    q_nxt   = ge ? {q[W-1:1], 1'b1} : q;
    rem_nxt = ge ? alu_r : rem;
  end

  always_comb begin
    alu_x  = '0;
    alu_y  = '0;
    alu_op = '0;
    case (state)
      CHK: begin
        alu_op = OP_OR;
        alu_x  = dvs;
      end
      CMP: begin
        alu_op = OP_SLT;
        alu_x  = s;
        alu_y  = dvs;
      end
      SUB: begin
        alu_op = OP_SUB;
        alu_x  = rem;
        alu_y  = dvs;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvs         <= '0;
      q           <= '0;
      rem         <= '0;
      cnt         <= '0;
      ge          <= 1'b0;
      dbz         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvs   <= divisor;
            q     <= dividend;
            busy  <= 1'b1;
            state <= CHK;
          end
        end
        CHK: begin
          if (alu_zero) begin
            // q still holds the latched dividend here
            dbz         <= 1'b1;
            quotient    <= '1;
            remainder   <= q;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            state       <= FIN;
          end else begin
            dbz   <= 1'b0;
            rem   <= '0;
            cnt   <= 5'd31;
            state <= CMP;
          end
        end
        CMP: begin
          ge    <= rem[W-1] | (alu_r == '0);
          rem   <= s;
          q     <= {q[W-2:0], 1'b0};
          state <= SUB;
        end
        SUB: begin
          rem <= rem_nxt;
          q   <= q_nxt;
          if (cnt == 5'd0) begin
            quotient    <= q_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= dbz;
            done        <= 1'b1;
            state       <= FIN;
          end else begin
            cnt   <= cnt - 5'd1;
            state <= CMP;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed and randomized checks of alu_div_sequencer against plain / and %
// arithmetic, with a simple ALU model closing the operand/result loop.
`timescale 1ns/1ps
module tb_alu_div_sequencer;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  logic [31:0] alu_x, alu_y, alu_r;
  logic [3:0]  alu_op;
  logic        alu_zero;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0]  ops[$];
  logic [3:0]  exp_ops[$];
  logic [31:0] c1x, c1y;
  logic [3:0]  c1op;
  logic [31:0] ra, rb;
  logic        prev_done;
  logic [31:0] hq, hr;

  always #5 clk = ~clk;

  alu_div_sequencer #(.W(32), .OP_OR(4'd1), .OP_SUB(4'd6), .OP_SLT(4'd7)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_r(alu_r), .alu_zero(alu_zero)
  );

  // ALU: OR=1, SUB=6, unsigned SLT=7
  always_comb begin
    case (alu_op)
      4'd1:    alu_r = alu_x | alu_y;
      4'd6:    alu_r = alu_x - alu_y;
      4'd7:    alu_r = (alu_x < alu_y) ? 32'd1 : 32'd0;
      default: alu_r = 32'd0;
    endcase
    alu_zero = (alu_r == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // done must be one cycle wide; results must hold between completions
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b0;
      hq = 32'd0;
      hr = 32'd0;
    end else begin
      if (done) begin
        check("done_single_cycle", {31'd0, prev_done}, 32'd0);
        hq = quotient;
        hr = remainder;
      end else begin
        check("quotient_stable", quotient, hq);
        check("remainder_stable", remainder, hr);
      end
      prev_done = done;
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit poke);
    int          lat, busy_cnt, errs, exp_lat;
    logic [31:0] eq, er;
    logic        ez;
    ops.delete();
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 100 && lat == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (busy) busy_cnt++;
      ops.push_back(alu_op);
      if (n == 1) begin
        c1x = alu_x;
        c1y = alu_y;
        c1op = alu_op;
      end
      if (poke) begin
        start    = (n == 10 || n == 40);
        dividend = $urandom;
        divisor  = $urandom | 32'd1;
      end
      if (done) lat = n;
    end
    start = 1'b0;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; ez = 1'b1; exp_lat = 2;
    end else begin
      eq = a / b; er = a % b; ez = 1'b0; exp_lat = 66;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
    check("chk_op", {28'd0, c1op}, 32'd1);
    check("chk_x", c1x, b);
    check("chk_y", c1y, 32'd0);
    exp_ops.delete();
    exp_ops.push_back(4'd1);
    if (b != 32'd0)
      for (int i = 0; i < 32; i++) begin
        exp_ops.push_back(4'd7);
        exp_ops.push_back(4'd6);
      end
    exp_ops.push_back(4'd0);
    errs = (ops.size() != exp_ops.size()) ? 1 : 0;
    for (int i = 0; i < ops.size() && i < exp_ops.size(); i++)
      if (ops[i] !== exp_ops[i]) errs++;
    check("alu_op_trace", 32'(errs), 32'd0);
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend = 32'd0;
    divisor = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_alu_op", {28'd0, alu_op}, 32'd0);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div(32'd1234, 32'd0, 1'b0);
    run_div(32'd5, 32'd10, 1'b0);
    run_div(32'd100, 32'd7, 1'b1);

    // asynchronous reset in the middle of a division (cycle 31 is a SUB cycle)
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_quotient", quotient, 32'd0);
    check("arst_remainder", remainder, 32'd0);
    check("arst_alu_op", {28'd0, alu_op}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_done", {31'd0, done}, 32'd0);
    end
    rst = 1'b0;
    run_div(32'd81, 32'd9, 1'b0);

    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = $urandom >> $urandom_range(0, 31);
        3:       rb = 32'h8000_0000 | $urandom;
        default: rb = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       ra = $urandom >> $urandom_range(0, 31);
        1:       ra = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: ra = $urandom;
      endcase
      run_div(ra, rb, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
